fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared fetch/PC parameters: access sizes and fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    // Instruction fetches are word accesses, so the low two PC bits must be zero.
    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Single-outstanding instruction fetch with decode handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_access_size,
    output logic        mem_rd_wr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    fetch_state_e r_state;
    logic [31:0]  r_req_pc;
    logic [31:0]  r_inst_data;
    logic [31:0]  r_inst_pc;
    logic         r_mem_req;
    logic         r_inst_valid;
    logic         r_fetch_fault;
    logic         r_drop_pending;

    logic         w_accept;
    logic         w_drop;

    // pc_advance must land in the accept cycle so the PC register has the
    // next address ready when IDLE samples it one cycle later.
    assign w_accept = (r_state == ST_HOLD) && inst_ready && !flush && !reset;
    assign w_drop   = r_drop_pending || flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_req_pc       <= 32'd0;
            r_inst_data    <= 32'd0;
            r_inst_pc      <= 32'd0;
            r_mem_req      <= 1'b0;
            r_inst_valid   <= 1'b0;
            r_fetch_fault  <= 1'b0;
            r_drop_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pc_aligned(pc_in[1:0])) begin
                        r_state   <= ST_REQ;
                        r_req_pc  <= pc_in;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state       <= ST_FAULT;
                        r_fetch_fault <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // The request cannot be withdrawn, so a flush here just
                    // marks the eventual response for discard.
                    if (flush) begin
                        r_drop_pending <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_drop_pending <= 1'b0;
                        if (w_drop) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_inst_data  <= mem_rdata;
                            r_inst_pc    <= r_req_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= ST_HOLD;
                        end
                    end else if (flush) begin
                        r_drop_pending <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush || inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_advance      = w_accept;
    assign mem_req         = r_mem_req;
    assign mem_addr        = r_req_pc;
    assign mem_access_size = ACC_WORD;
    assign mem_rd_wr       = 1'b0;
    assign inst_valid      = r_inst_valid;
    assign inst_data       = r_inst_data;
    assign inst_pc         = r_inst_pc;
    assign fetch_fault     = r_fetch_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed scoreboard bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_access_size;
    logic        mem_rd_wr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_total;
    int   n_bad;
    int   n_adv;

    fetch_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_advance      (pc_advance),
        .flush           (flush),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_access_size (mem_access_size),
        .mem_rd_wr       (mem_rd_wr),
        .mem_ack         (mem_ack),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: check handoff/pc_advance mid-cycle, then act as the PC register.
    task automatic step();
        logic adv_exp;
        logic adv_seen;
        exp_t e;
        @(negedge clk);
        adv_exp  = inst_valid && inst_ready && !flush;
        adv_seen = pc_advance;
        chk("pc_advance", {31'd0, adv_seen}, {31'd0, adv_exp});
        if (adv_exp) begin
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("handoff_pc", inst_pc, e.pc);
                chk("handoff_data", inst_data, e.data);
            end
        end
        if (adv_seen) n_adv++;
        @(posedge clk);
        #1;
        if (adv_seen) pc_in = pc_in + 32'd4;
    endtask

    initial begin
        n_total = 0; n_bad = 0; n_adv = 0;
        reset = 1'b1; pc_in = 32'd0; flush = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; inst_ready = 1'b0;
        step(); step();

        chk("rst_mem_req",  {31'd0, mem_req},     32'd0);
        chk("rst_valid",    {31'd0, inst_valid},  32'd0);
        chk("rst_fault",    {31'd0, fetch_fault}, 32'd0);
        chk("rst_data",     inst_data,            32'd0);
        chk("rst_pc",       inst_pc,              32'd0);
        chk("rst_addr",     mem_addr,             32'd0);
        chk("acc_size",     {30'd0, mem_access_size}, 32'd2);
        chk("rd_wr",        {31'd0, mem_rd_wr},   32'd0);

        // Basic fetch at PC 0 with minimum latency
        reset = 1'b0;
        step();
        chk("s1_req", {31'd0, mem_req}, 32'd1);
        chk("s1_addr", mem_addr, 32'h0);
        mem_ack = 1'b1;
        step();
        chk("s1_req_drop", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2008_0005;
        sb.push_back('{pc: 32'h0, data: 32'h2008_0005});
        inst_ready = 1'b1;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        chk("s1_valid", {31'd0, inst_valid}, 32'd1);
        chk("s1_data", inst_data, 32'h2008_0005);
        chk("s1_ipc", inst_pc, 32'h0);
        step();
        chk("s1_valid_off", {31'd0, inst_valid}, 32'd0);
        step();
        chk("s1_next_addr", mem_addr, 32'h4);
        chk("s1_next_req", {31'd0, mem_req}, 32'd1);

        // Decode back-pressure for 5 cycles
        inst_ready = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        sb.push_back('{pc: 32'h4, data: 32'h1111_2222});
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            chk("s2_hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("s2_hold_data", inst_data, 32'h1111_2222);
            chk("s2_hold_pc", inst_pc, 32'h4);
            step();
        end
        inst_ready = 1'b1;
        step();
        step();
        chk("s2_next_addr", mem_addr, 32'h8);

        // Flush while waiting for data; branch target supplied afterwards
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; pc_in = 32'h40;
        step();
        chk("s4_no_valid_a", {31'd0, inst_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("s4_no_valid_b", {31'd0, inst_valid}, 32'd0);
        chk("s4_data_kept", inst_data, 32'h1111_2222);
        step();
        chk("s4_new_req", {31'd0, mem_req}, 32'd1);
        chk("s4_new_addr", mem_addr, 32'h40);

        // Ack delayed 3 cycles; stray rvalid during REQ must be ignored
        for (int i = 0; i < 4; i++) begin
            chk("s3_req_held", {31'd0, mem_req}, 32'd1);
            chk("s3_addr_held", mem_addr, 32'h40);
            mem_rvalid = (i == 1);
            mem_rdata  = 32'hBAAD_F00D;
            mem_ack    = (i == 3);
            step();
        end
        mem_ack = 1'b0; mem_rvalid = 1'b0;
        chk("s3_no_valid", {31'd0, inst_valid}, 32'd0);
        chk("s3_req_off", {31'd0, mem_req}, 32'd0);
        step();
        chk("s3_no_second_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0093;
        sb.push_back('{pc: 32'h40, data: 32'h00A0_0093});
        step();
        mem_rvalid = 1'b0;
        chk("s3_valid", {31'd0, inst_valid}, 32'd1);
        step();
        step();
        chk("s3_next_addr", mem_addr, 32'h44);

        // Flush during REQ: request kept until ack, response dropped
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s5_req_kept", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_rvalid = 1'b0;
        chk("s5_no_valid", {31'd0, inst_valid}, 32'd0);
        chk("s5_data_kept", inst_data, 32'h00A0_0093);
        step();
        chk("s5_reissue", mem_addr, 32'h44);

        // ack+rvalid together (rvalid ignored), then flush in HOLD beats ready
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        step();
        chk("s6_no_skip", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        chk("s6_valid", {31'd0, inst_valid}, 32'd1);
        chk("s6_data", inst_data, 32'h1234_5678);
        chk("s6_ipc", inst_pc, 32'h44);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s6_flushed", {31'd0, inst_valid}, 32'd0);
        step();
        chk("s6_same_addr", mem_addr, 32'h44);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        sb.push_back('{pc: 32'h44, data: 32'h0BAD_F00D});
        step();
        mem_rvalid = 1'b0;
        step();
        step();
        chk("s6_next_addr", mem_addr, 32'h48);

        // Reset in WAIT, late rvalid afterwards
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        chk("s7_no_valid", {31'd0, inst_valid}, 32'd0);
        chk("s7_data_clr", inst_data, 32'd0);
        chk("s7_req", {31'd0, mem_req}, 32'd1);
        chk("s7_addr", mem_addr, 32'h48);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0041_0113;
        sb.push_back('{pc: 32'h48, data: 32'h0041_0113});
        step();
        mem_rvalid = 1'b0;
        step();
        chk("s7_pc_adv", pc_in, 32'h4C);

        // Misaligned PC: absorbing fault until reset
        pc_in = 32'h6;
        step();
        chk("s8_fault", {31'd0, fetch_fault}, 32'd1);
        chk("s8_no_req", {31'd0, mem_req}, 32'd0);
        pc_in = 32'h50; flush = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s8_fault_sticky", {31'd0, fetch_fault}, 32'd1);
            chk("s8_req_off", {31'd0, mem_req}, 32'd0);
            chk("s8_valid_off", {31'd0, inst_valid}, 32'd0);
        end
        flush = 1'b0; mem_ack = 1'b0; reset = 1'b1;
        step();
        chk("s8_fault_clr", {31'd0, fetch_fault}, 32'd0);
        reset = 1'b0;
        step();
        chk("s8_restart_req", {31'd0, mem_req}, 32'd1);
        chk("s8_restart_addr", mem_addr, 32'h50);

        chk("adv_count", n_adv, 32'd5);
        chk("sb_left", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
